updown_seq_ctrl: RTL and testbench

UPDOWN_SEQ_CTRL -- requirements
Module: updown_seq_ctrl

---
 rtl/updown_seq_ctrl_if.sv | 25 ++
 rtl/updown_seq_ctrl.sv | 138 +++++++++++++
 tb/tb_updown_seq_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/updown_seq_ctrl_if.sv
// rtl/updown_seq_ctrl_if.sv - command channel into the up/down sequence controller
// The requester drives the master side; the controller's queue is the slave.
interface updown_seq_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_up;
  logic [3:0] cmd_load;
  logic [3:0] cmd_len;

  modport master (
    output cmd_valid,
    output cmd_up,
    output cmd_load,
    output cmd_len,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_up,
    input  cmd_load,
    input  cmd_len,
    output cmd_ready
  );
endinterface

// File: rtl/updown_seq_ctrl.sv
// rtl/updown_seq_ctrl.sv - queued up/down counter sequencer
// Commands wait in a FIFO; the FSM loads, steps the 4-bit counter and pulses done.
module updown_seq_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  updown_seq_ctrl_if.slave        cmd,
  input  logic                    abort,
  output logic [3:0]              count,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic                    wrap,
  output logic [$clog2(DEPTH):0]  q_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        state;
  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          head_up;
  logic [3:0]    head_load;
  logic [3:0]    head_len;
  logic          dir;
  logic [3:0]    remaining;
  logic [3:0]    next_count;
  logic          step_wraps;

  assign full          = (level == LW'(DEPTH));
  assign empty         = (level == '0);
  assign cmd.cmd_ready = !full && !rst;
  assign push          = cmd.cmd_valid && cmd.cmd_ready;
  // Popping only from registered level keeps a fresh push out of the same edge's pop.
  assign pop           = (state == S_IDLE) && !empty;
  assign {head_up, head_load, head_len} = mem[rd_ptr];
  assign next_count    = dir ? (count + 4'd1) : (count - 4'd1);
  assign step_wraps    = dir ? (count == 4'hF) : (count == 4'h0);
  assign q_level       = level;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd.cmd_up, cmd.cmd_load, cmd.cmd_len};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      count     <= 4'b0000;
      remaining <= 4'd0;
      dir       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      wrap    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            count     <= head_load;
            remaining <= head_len;
            dir       <= head_up;
            busy      <= 1'b1;
            if (head_len != 4'd0) begin
              state <= S_RUN;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          // Abort wins over the step, so the count freezes at its current value.
          if (abort) begin
            state   <= S_DONE;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else begin
            count     <= next_count;
            wrap      <= step_wraps;
            remaining <= remaining - 4'd1;
            if (remaining == 4'd1) begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_updown_seq_ctrl.sv
// tb/tb_updown_seq_ctrl.sv - scoreboard bench for updown_seq_ctrl
// Stimulus queues expected completions; a negedge monitor checks each done pulse.
module tb_updown_seq_ctrl;
  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   abort = 1'b0;
  logic [3:0]             count;
  logic                   busy;
  logic                   done;
  logic                   aborted;
  logic                   wrap;
  logic [$clog2(DEPTH):0] q_level;

  updown_seq_ctrl_if cif ();

  updown_seq_ctrl #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .cmd     (cif),
    .abort   (abort),
    .count   (count),
    .busy    (busy),
    .done    (done),
    .aborted (aborted),
    .wrap    (wrap),
    .q_level (q_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cnt;
    int         wraps;
    logic       ab;
  } exp_t;

  typedef struct {
    logic       up;
    logic [3:0] load;
    logic [3:0] len;
    logic [3:0] fin;
    int         wraps;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   wcnt = 0;

  int   down_cnt[4]  = '{1, 0, 15, 14};
  int   down_wrap[4] = '{0, 0, 1, 0};
  // Hand-computed results for the fill test: final = (load +/- len) mod 16.
  vec_t fill_vec[6] = '{
    '{1'b1, 4'd2,  4'd5, 4'd7,  0},
    '{1'b0, 4'd5,  4'd2, 4'd3,  0},
    '{1'b1, 4'd14, 4'd3, 4'd1,  1},
    '{1'b1, 4'd9,  4'd0, 4'd9,  0},
    '{1'b0, 4'd0,  4'd1, 4'd15, 1},
    '{1'b1, 4'd15, 4'd1, 4'd0,  1}
  };

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic push_cmd(input logic up, input logic [3:0] load, input logic [3:0] len,
                          input logic [3:0] ecnt, input int ewr, input logic eab);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    cif.cmd_valid = 1'b1;
    cif.cmd_up    = up;
    cif.cmd_load  = load;
    cif.cmd_len   = len;
    while (!cif.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!cif.cmd_ready) begin
      failures++;
      $display("FAIL push_timeout actual=not_accepted expected=accepted");
      cif.cmd_valid = 1'b0;
    end else begin
      e = '{ecnt, ewr, eab};
      sb.push_back(e);
      @(posedge clk);
      #1;
      cif.cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || q_level != 0 || sb.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", n < 1000, 1);
  endtask

  task automatic wait_count(input int c);
    int n = 0;
    while (!(busy && count == 4'(c)) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_count_timeout", n < 200, 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      wcnt = 0;
    end else begin
      if (wrap) wcnt++;
      chk("aborted_without_done", int'(aborted && !done), 0);
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, int'(sb.size()));
        end else begin
          e = sb.pop_front();
          chk("done_count", count, e.cnt);
          chk("done_aborted", aborted, e.ab);
          chk("done_wraps", wcnt, e.wraps);
        end
        wcnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    cif.cmd_valid = 1'b0;
    cif.cmd_up    = 1'b0;
    cif.cmd_load  = 4'd0;
    cif.cmd_len   = 4'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q_level", q_level, 0);
    chk("rst_ready", cif.cmd_ready, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", cif.cmd_ready, 1);

    // Count up 3 -> 7
    push_cmd(1'b1, 4'd3, 4'd4, 4'd7, 0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("up_seq", count, 3 + k);
    end
    chk("up_done_pulse", done, 1);
    wait_idle();

    // Count down across zero
    push_cmd(1'b0, 4'd1, 4'd3, 4'd14, 1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk("down_seq", count, down_cnt[k]);
      chk("down_wrap", wrap, down_wrap[k]);
    end
    wait_idle();

    // Zero-length command
    push_cmd(1'b1, 4'd0, 4'd0, 4'd0, 0, 1'b0);
    @(posedge clk);
    #1;
    chk("len0_done", done, 1);
    chk("len0_count", count, 0);
    chk("len0_wrap", wrap, 0);
    wait_idle();

    // Fill the queue while idle; head is popped so DEPTH+1 fit
    for (int i = 0; i < DEPTH + 1; i++) begin
      push_cmd(fill_vec[i].up, fill_vec[i].load, fill_vec[i].len,
               fill_vec[i].fin, fill_vec[i].wraps, 1'b0);
    end
    chk("fill_ready_low", cif.cmd_ready, 0);
    chk("fill_level", q_level, DEPTH);
    push_cmd(fill_vec[5].up, fill_vec[5].load, fill_vec[5].len,
             fill_vec[5].fin, fill_vec[5].wraps, 1'b0);
    wait_idle();

    // Abort after three steps; abort held through DONE and IDLE is ignored
    push_cmd(1'b1, 4'd8, 4'd10, 4'd11, 0, 1'b1);
    push_cmd(1'b0, 4'd4, 4'd2, 4'd2, 0, 1'b0);
    wait_count(11);
    abort = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_count", count, 11);
    chk("abort_done", done, 1);
    chk("abort_flag", aborted, 1);
    @(posedge clk);
    #1;
    chk("abort_hold", count, 11);
    chk("abort_done_once", done, 0);
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("after_abort_load", count, 4);
    chk("after_abort_busy", busy, 1);
    wait_idle();

    // Reset during RUN discards everything
    push_cmd(1'b1, 4'd1, 4'd6, 4'd0, 0, 1'b0);
    push_cmd(1'b1, 4'd2, 4'd3, 4'd0, 0, 1'b0);
    wait_count(3);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_count", count, 0);
    chk("midrst_level", q_level, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_ready", cif.cmd_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle", busy, 0);
    push_cmd(1'b0, 4'd7, 4'd4, 4'd3, 0, 1'b0);
    wait_idle();

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
